// File: rtl/alu_reg_pkg.sv
// Shared definitions for the ALU operand register file.
// Holds the default geometry of the register file and the operand word type
// used by the ALU bit-slices.
package alu_reg_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 3;

  typedef logic [ALU_WIDTH-1:0] operand_t;

endpackage

// File: rtl/alu_operand_read_port.sv
// One registered read port of the ALU operand register file.
// Selects a register from the flattened array, forces register 0 to zero
// when ZERO_REG=1, and registers the result toward the ALU.
// Optional write-through forwarding is built only when
// ALU_OPERAND_REGFILE_BYPASS_EN is defined.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   rd_en          capture a new operand this cycle (else hold)
//   addr           register index to read
//   regs           current register array contents
//   wr_en, wd_addr, wd_data   write port (present only with bypass)
//   operand        registered operand to the ALU
import alu_reg_pkg::*;

module alu_operand_read_port #(
  parameter int WIDTH    = ALU_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
`ifdef ALU_OPERAND_REGFILE_BYPASS_EN
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wd_addr,
  input  logic [WIDTH-1:0]             wd_data,
`endif
  output logic [WIDTH-1:0]             operand
);

  logic             is_zero_reg;
  logic [WIDTH-1:0] rd_word;

  assign is_zero_reg = (ZERO_REG != 0) && (addr == '0);

  always_comb begin
    rd_word = regs[addr];
    if (is_zero_reg) begin
      rd_word = '0;
    end
`ifdef ALU_OPERAND_REGFILE_BYPASS_EN
    // Forward the result being written this cycle; register 0 is never
    // forwarded because the write to it is discarded.
    if (wr_en && (wd_addr == addr) && !is_zero_reg) begin
      rd_word = wd_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      operand <= '0;
    end else if (rd_en) begin
      operand <= rd_word;
    end
  end

endmodule

// File: rtl/alu_operand_regfile.sv
// Register file feeding the ALU bit-slices (including MOV).
// Holds DEPTH registers of WIDTH bits, one write port for the ALU result and
// two registered read ports producing R1/R2 with a one-cycle latency.
// Optional feature: define ALU_OPERAND_REGFILE_BYPASS_EN to forward a
// same-cycle write to the read ports; otherwise reads see the old contents.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   rd_en                 capture a new operand pair this cycle
//   rs1_addr, rs2_addr    source register indices
//   R1, R2                registered operands (R2 feeds MOV)
//   operand_valid         R1/R2 were updated at the last edge
//   wr_en                 write the ALU result this cycle
//   wd_addr, wd_data      destination index and result value
//   wr_ack                write committed at the last edge
import alu_reg_pkg::*;

module alu_operand_regfile #(
  parameter int WIDTH    = ALU_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  R1,
  output logic [WIDTH-1:0]  R2,
  output logic              operand_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wd_addr,
  input  logic [WIDTH-1:0]  wd_data,
  output logic              wr_ack
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        wr_commit;

  // A write to register 0 is acknowledged but leaves the array unchanged.
  assign wr_commit = wr_en && !((ZERO_REG != 0) && (wd_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      regs          <= '0;
      wr_ack        <= 1'b0;
      operand_valid <= 1'b0;
    end else begin
      if (wr_commit) begin
        regs[wd_addr] <= wd_data;
      end
      wr_ack        <= wr_en;
      operand_valid <= rd_en;
    end
  end

  alu_operand_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port1 (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .addr    (rs1_addr),
    .regs    (regs),
`ifdef ALU_OPERAND_REGFILE_BYPASS_EN
    .wr_en   (wr_en),
    .wd_addr (wd_addr),
    .wd_data (wd_data),
`endif
    .operand (R1)
  );

  alu_operand_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port2 (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .addr    (rs2_addr),
    .regs    (regs),
`ifdef ALU_OPERAND_REGFILE_BYPASS_EN
    .wr_en   (wr_en),
    .wd_addr (wd_addr),
    .wd_data (wd_data),
`endif
    .operand (R2)
  );

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed, table-driven bench for alu_operand_regfile (default parameters).
// Expected results for same-cycle read/write collisions follow
// ALU_OPERAND_REGFILE_BYPASS_EN.
module tb_alu_operand_regfile;

`ifdef ALU_OPERAND_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, rd_en, wr_en;
  logic [2:0] rs1_addr, rs2_addr, wd_addr;
  logic [3:0] wd_data;
  logic [3:0] R1, R2;
  logic       operand_valid, wr_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_operand_regfile #(
    .WIDTH    (4),
    .DEPTH    (8),
    .ADDR_W   (3),
    .ZERO_REG (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .R1            (R1),
    .R2            (R2),
    .operand_valid (operand_valid),
    .wr_en         (wr_en),
    .wd_addr       (wd_addr),
    .wd_data       (wd_data),
    .wr_ack        (wr_ack)
  );

  typedef struct {
    logic       rst;
    logic       rd_en;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       wr_en;
    logic [2:0] wa;
    logic [3:0] wd;
    logic [3:0] r1;
    logic [3:0] r2;
    logic       valid;
    logic       ack;
  } vec_t;

  function automatic vec_t mk(logic r, logic re, logic [2:0] a1, logic [2:0] a2,
                              logic we, logic [2:0] wa, logic [3:0] wd,
                              logic [3:0] e1, logic [3:0] e2, logic ev, logic ea);
    vec_t v;
    v.rst = r; v.rd_en = re; v.rs1 = a1; v.rs2 = a2;
    v.wr_en = we; v.wa = wa; v.wd = wd;
    v.r1 = e1; v.r2 = e2; v.valid = ev; v.ack = ea;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic re, input logic [2:0] a1,
                       input logic [2:0] a2, input logic we, input logic [2:0] wa,
                       input logic [3:0] wd);
    rst = r; rd_en = re; rs1_addr = a1; rs2_addr = a2;
    wr_en = we; wd_addr = wa; wd_data = wd;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[21];
  logic [3:0] col;   // collision result: old contents or forwarded value
  logic [3:0] wb;    // value of reg 7 read in the same cycle it is written

  initial begin
    col = BYP ? 4'h7 : 4'h1;
    wb  = BYP ? 4'hB : 4'h0;
    //             rst re rs1 rs2 we wa wd     R1    R2    v  ack
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 4'h0,  4'h0, 4'h0, 0, 0);
    vecs[1]  = mk(0, 1, 3, 5, 0, 0, 4'h0,  4'h0, 4'h0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 2, 4'hA,  4'h0, 4'h0, 0, 1);
    vecs[3]  = mk(0, 1, 0, 2, 0, 0, 4'h0,  4'h0, 4'hA, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 3, 4'h5,  4'h0, 4'hA, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 1, 6, 4'hC,  4'h0, 4'hA, 0, 1);
    vecs[6]  = mk(0, 1, 3, 6, 0, 0, 4'h0,  4'h5, 4'hC, 1, 0);
    vecs[7]  = mk(0, 0, 3, 6, 1, 3, 4'h1,  4'h5, 4'hC, 0, 1);
    vecs[8]  = mk(0, 0, 3, 6, 1, 6, 4'h2,  4'h5, 4'hC, 0, 1);
    vecs[9]  = mk(0, 0, 3, 6, 1, 3, 4'hF,  4'h5, 4'hC, 0, 1);
    vecs[10] = mk(0, 1, 3, 6, 0, 0, 4'h0,  4'hF, 4'h2, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, 4, 4'h1,  4'hF, 4'h2, 0, 1);
    vecs[12] = mk(0, 1, 4, 4, 1, 4, 4'h7,  col,  col,  1, 1);
    vecs[13] = mk(0, 1, 4, 4, 0, 0, 4'h0,  4'h7, 4'h7, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 0, 4'hF,  4'h7, 4'h7, 0, 1);
    vecs[15] = mk(0, 1, 0, 0, 0, 0, 4'h0,  4'h0, 4'h0, 1, 0);
    vecs[16] = mk(1, 1, 1, 2, 1, 1, 4'h9,  4'h0, 4'h0, 0, 0);
    vecs[17] = mk(0, 1, 1, 2, 0, 0, 4'h0,  4'h0, 4'h0, 1, 0);
    vecs[18] = mk(0, 1, 0, 3, 1, 0, 4'h5,  4'h0, 4'h0, 1, 1);
    vecs[19] = mk(0, 1, 7, 1, 1, 7, 4'hB,  wb,   4'h0, 1, 1);
    vecs[20] = mk(0, 1, 7, 7, 0, 0, 4'h0,  4'hB, 4'hB, 1, 0);

    drive(1, 0, 0, 0, 0, 0, 4'h0);
    for (int unsigned i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].rd_en, vecs[i].rs1, vecs[i].rs2,
            vecs[i].wr_en, vecs[i].wa, vecs[i].wd);
      check("R1", int'(i), R1, vecs[i].r1);
      check("R2", int'(i), R2, vecs[i].r2);
      check("operand_valid", int'(i), {3'b0, operand_valid}, {3'b0, vecs[i].valid});
      check("wr_ack", int'(i), {3'b0, wr_ack}, {3'b0, vecs[i].ack});
    end

    // Back-to-back pipeline from a clean reset: each cycle writes reg i and
    // reads reg i-1 (written last cycle) on R1 and reg i (written now) on R2.
    drive(1, 0, 0, 0, 0, 0, 4'h0);
    for (int unsigned i = 0; i <= 8; i++) begin
      logic [3:0] d_prev, d_now, e1, e2;
      logic [2:0] a_now, a_prev;
      a_now  = 3'(i);
      a_prev = 3'(i - 1);
      d_now  = 4'((i * 3 + 1) & 15);
      d_prev = 4'(((i - 1) * 3 + 1) & 15);
      drive(0, i > 0, a_prev, a_now, i < 8, a_now, d_now);
      if (i > 0) begin
        e1 = (a_prev == 3'd0) ? 4'h0 : d_prev;
        e2 = (BYP && i < 8) ? d_now : 4'h0;
        check("pipe_R1", int'(i), R1, e1);
        check("pipe_R2", int'(i), R2, e2);
        check("pipe_valid", int'(i), {3'b0, operand_valid}, 4'h1);
      end
      check("pipe_ack", int'(i), {3'b0, wr_ack}, (i < 8) ? 4'h1 : 4'h0);
    end

    // Reset in the middle of a back-to-back stream clears outputs at once,
    // and the first fresh operands only appear one capture later.
    drive(0, 1, 5, 6, 1, 5, 4'hE);
    drive(1, 1, 5, 6, 1, 6, 4'hD);
    check("mid_rst_R1", 0, R1, 4'h0);
    check("mid_rst_valid", 0, {3'b0, operand_valid}, 4'h0);
    check("mid_rst_ack", 0, {3'b0, wr_ack}, 4'h0);
    drive(0, 1, 5, 6, 0, 0, 4'h0);
    check("post_rst_R1", 0, R1, 4'h0);
    check("post_rst_R2", 0, R2, 4'h0);
    check("post_rst_valid", 0, {3'b0, operand_valid}, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
